// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    localparam int   DWIDTH_DEF   = 8;
    localparam int   DIVWIDTH_DEF = 16;
    localparam logic TXD_IDLE     = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO read port between the TX FIFO (slave) and the serializer (master).
interface uart_tx_serializer_if
    import uart_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);
    // fifo_rd is a single-cycle pop, only legal while fifo_empty is low;
    // fifo_rdata is valid from the cycle after the pop until the next pop.
    logic              fifo_empty;
    logic              fifo_rd;
    logic [DWIDTH-1:0] fifo_rdata;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_rd
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: load with div (>=1) at each bit start, tick on terminal count.
module uart_baud_tick #(
    parameter int DIVWIDTH = 16
) (
    input  logic                clk,
    input  logic                s_reset,
    input  logic                load,
    input  logic [DIVWIDTH-1:0] div,
    output logic                tick
);

    logic [DIVWIDTH-1:0] cnt_q;
    logic [DIVWIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = div - DIVWIDTH'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIVWIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// Pops words from the TX FIFO and sends them LSB-first as 8N1/8N2 UART frames.
// Optional parity bit (8E1/8O1) when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int DIVWIDTH = DIVWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 s_reset,
    input  logic [DIVWIDTH-1:0]  baud_div,
    input  logic                 stop2,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    uart_tx_serializer_if.master fifo_if,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done,
    output tx_state_t            dbg_state
);

    localparam int             IDXW     = $clog2(DWIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DWIDTH - 1);

    tx_state_t           state_q, state_d;
    logic [DWIDTH-1:0]   shreg_q, shreg_d;
    logic [IDXW-1:0]     bit_idx_q, bit_idx_d;
    logic [DIVWIDTH-1:0] div_q, div_d;
    logic                stop2_q, stop2_d;
    logic                stop_sec_q, stop_sec_d;
    logic                txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    logic [DIVWIDTH-1:0] div_new;
    logic [DIVWIDTH-1:0] tick_div;
    logic                tick_load;
    logic                bit_tick;

    assign div_new  = (baud_div == '0) ? DIVWIDTH'(1) : baud_div;
    // The counter is armed in LOAD with the fresh divisor, then re-armed at each bit end.
    assign tick_div  = (state_q == LOAD) ? div_new : div_q;
    assign tick_load = (state_q == LOAD) ||
                       (bit_tick && (state_q inside {START, DATA, PARITY, STOP}));

    uart_baud_tick #(
        .DIVWIDTH(DIVWIDTH)
    ) u_baud_tick (
        .clk     (clk),
        .s_reset (s_reset),
        .load    (tick_load),
        .div     (tick_div),
        .tick    (bit_tick)
    );

    assign fifo_if.fifo_rd = (state_q == IDLE) && !fifo_if.fifo_empty && !s_reset;
    assign busy            = (state_q != IDLE);
    assign txd             = txd_q;
    assign dbg_state       = state_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        div_d      = div_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        tx_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_if.fifo_empty && !s_reset) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d    = fifo_if.fifo_rdata;
                div_d      = div_new;
                stop2_d    = stop2;
                stop_sec_d = 1'b0;
                bit_idx_d  = '0;
`ifdef UART_TX_PARITY_EN
                par_d      = (^fifo_if.fifo_rdata) ^ parity_odd;
`endif
                state_d    = START;
            end
            START: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDXW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // txd is registered from the next state so the pad sees a glitch-free line.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = TXD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            div_q      <= '0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            txd_q      <= TXD_IDLE;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            div_q      <= div_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: table of single frames plus back-to-back and reset sequences.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] baud;
        logic        stop2;
        logic        par_odd;
        logic        mid_change;
        int          div_eff;
        int          clocks;
        logic [11:0] bits;     // bit 0 = start bit, one entry per bit period
    } vec_t;

    // clock / reset
    logic clk;
    logic s_reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] baud_div;
    logic        stop2;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd;
`endif
    logic        txd;
    logic        busy;
    logic        tx_done;
    tx_state_t   dbg_state;

    uart_tx_serializer_if #(.DWIDTH(8)) fif ();

    uart_tx_serializer #(
        .DWIDTH   (8),
        .DIVWIDTH (16)
    ) dut (
        .clk        (clk),
        .s_reset    (s_reset),
        .baud_div   (baud_div),
        .stop2      (stop2),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .fifo_if    (fif.master),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done),
        .dbg_state  (dbg_state)
    );

    // FIFO model: registered read data, valid the cycle after the pop
    logic [7:0] mem [16];
    int         pushed_cnt = 0;
    int         popped_cnt = 0;

    assign fif.fifo_empty = (pushed_cnt == popped_cnt);

    always @(posedge clk) begin
        if (fif.fifo_rd && (pushed_cnt != popped_cnt)) begin
            fif.fifo_rdata <= mem[popped_cnt % 16];
            popped_cnt     <= popped_cnt + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[pushed_cnt % 16] = b;
        pushed_cnt = pushed_cnt + 1;
    endtask

    // scoreboard counters
    int checks = 0;
    int errors = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called at a sample point where the DUT is IDLE and the FIFO is non-empty.
    task automatic run_frame(input vec_t v, input int id);
        logic exp_b;
        logic [11:0] bits;
        bits = v.bits;
        check_bit($sformatf("v%0d pop", id), fif.fifo_rd, 1'b1);
        check_bit($sformatf("v%0d busy_pre", id), busy, 1'b0);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk); #1;
            check_bit($sformatf("v%0d lead txd c=%0d", id, c), txd, 1'b1);
            check_bit($sformatf("v%0d lead busy c=%0d", id, c), busy, 1'b1);
            check_bit($sformatf("v%0d lead rd c=%0d", id, c), fif.fifo_rd, 1'b0);
        end
        for (int k = 0; k < v.clocks; k++) begin
            @(negedge clk);
            if (v.mid_change && k == 2) begin
                baud_div = 16'd7;
                stop2    = 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_odd = ~parity_odd;
`endif
            end
            #1;
            exp_b = bits[k / v.div_eff];
            check_bit($sformatf("v%0d txd k=%0d", id, k), txd, exp_b);
            check_bit($sformatf("v%0d busy k=%0d", id, k), busy, 1'b1);
            check_bit($sformatf("v%0d rd k=%0d", id, k), fif.fifo_rd, 1'b0);
            check_bit($sformatf("v%0d done k=%0d", id, k), tx_done, (k == v.clocks - 1));
        end
        @(negedge clk); #1;
        check_bit($sformatf("v%0d busy_post", id), busy, 1'b0);
        check_bit($sformatf("v%0d txd_post", id), txd, 1'b1);
        check_bit($sformatf("v%0d done_post", id), tx_done, 1'b0);
    endtask

`ifdef UART_TX_PARITY_EN
    localparam int NV = 7;
`else
    localparam int NV = 6;
`endif
    vec_t vecs [NV];
    vec_t va, vb, vr;

    initial begin
`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'h55, 16'd4, 1'b0, 1'b0, 1'b0, 4, 44, 12'b010010101010};
        vecs[1] = '{8'hA3, 16'd2, 1'b0, 1'b0, 1'b0, 2, 22, 12'b010101000110};
        vecs[2] = '{8'hFF, 16'd0, 1'b0, 1'b0, 1'b0, 1, 11, 12'b010111111110};
        vecs[3] = '{8'h00, 16'd3, 1'b1, 1'b0, 1'b0, 3, 36, 12'b110000000000};
        vecs[4] = '{8'h07, 16'd1, 1'b0, 1'b0, 1'b0, 1, 11, 12'b011000001110};
        vecs[5] = '{8'h07, 16'd1, 1'b0, 1'b1, 1'b0, 1, 11, 12'b010000001110};
        vecs[6] = '{8'h0F, 16'd1, 1'b0, 1'b0, 1'b1, 1, 11, 12'b010000011110};
        va      = '{8'hA3, 16'd2, 1'b0, 1'b0, 1'b0, 2, 22, 12'b010101000110};
        vb      = '{8'h0F, 16'd2, 1'b0, 1'b0, 1'b0, 2, 22, 12'b010000011110};
        vr      = '{8'h3C, 16'd4, 1'b0, 1'b0, 1'b0, 4, 44, 12'b010001111000};
`else
        vecs[0] = '{8'h55, 16'd4, 1'b0, 1'b0, 1'b0, 4, 40, 12'b001010101010};
        vecs[1] = '{8'hA3, 16'd2, 1'b0, 1'b0, 1'b0, 2, 20, 12'b001101000110};
        vecs[2] = '{8'hFF, 16'd0, 1'b0, 1'b0, 1'b0, 1, 10, 12'b001111111110};
        vecs[3] = '{8'h00, 16'd3, 1'b1, 1'b0, 1'b0, 3, 33, 12'b011000000000};
        vecs[4] = '{8'h0F, 16'd1, 1'b0, 1'b0, 1'b1, 1, 10, 12'b001000011110};
        vecs[5] = '{8'hC6, 16'd5, 1'b0, 1'b0, 1'b0, 5, 50, 12'b001110001100};
        va      = '{8'hA3, 16'd2, 1'b0, 1'b0, 1'b0, 2, 20, 12'b001101000110};
        vb      = '{8'h0F, 16'd2, 1'b0, 1'b0, 1'b0, 2, 20, 12'b001000011110};
        vr      = '{8'h3C, 16'd4, 1'b0, 1'b0, 1'b0, 4, 40, 12'b001001111000};
`endif

        // reset state
        s_reset  = 1'b1;
        baud_div = 16'd4;
        stop2    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check_bit("rst txd", txd, 1'b1);
        check_bit("rst busy", busy, 1'b0);
        check_bit("rst rd", fif.fifo_rd, 1'b0);
        check_bit("rst done", tx_done, 1'b0);
        check_bit("rst state_idle", dbg_state == IDLE, 1'b1);
        @(negedge clk);
        s_reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_bit("idle rd_empty", fif.fifo_rd, 1'b0);
        check_bit("idle txd", txd, 1'b1);

        // table of single frames
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            baud_div = vecs[i].baud;
            stop2    = vecs[i].stop2;
`ifdef UART_TX_PARITY_EN
            parity_odd = vecs[i].par_odd;
`endif
            push(vecs[i].data);
            #1;
            run_frame(vecs[i], i);
            check_bit($sformatf("v%0d rd_after", i), fif.fifo_rd, 1'b0);
            repeat (2) @(negedge clk);
        end

        // back-to-back frames: 3-clock high gap, busy low only on the IDLE cycle
        @(negedge clk);
        baud_div = 16'd2;
        stop2    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        push(8'hA3);
        push(8'h0F);
        #1;
        run_frame(va, 100);
        run_frame(vb, 101);
        check_bit("b2b rd_after", fif.fifo_rd, 1'b0);

        // reset in the middle of DATA, then a fresh frame from the remaining word
        @(negedge clk);
        baud_div = 16'd4;
        push(8'h55);
        push(8'h3C);
        #1;
        check_bit("rstmid pop", fif.fifo_rd, 1'b1);
        repeat (15) @(negedge clk);
        #1;
        check_bit("rstmid in_data", dbg_state == DATA, 1'b1);
        s_reset = 1'b1;
        @(negedge clk); #1;
        check_bit("rstmid txd", txd, 1'b1);
        check_bit("rstmid busy", busy, 1'b0);
        check_bit("rstmid rd", fif.fifo_rd, 1'b0);
        check_bit("rstmid done", tx_done, 1'b0);
        s_reset = 1'b0;
        #1;
        run_frame(vr, 200);
        check_bit("rstmid rd_after", fif.fifo_rd, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
